ad4003_adc_emulator: RTL and testbench

Synthesizable responder model of one AD4003 lane in 3-wire turbo mode: the ADC end of the CNV/SCK/SDI/SDO link that the ADC acquisition deserializer drives. It oversamples the host's CNV, SCK and SDI on the system clock and shifts 18-bit samples out on SDO. It also decodes the 16-bit register write/read commands sent on SDI. It is used for FPGA loopback and bench verification of the acquisition path without real converters, one instance per lane (A, B).

---
 rtl/ad4003_pkg.sv | 21 ++
 rtl/ad4003_adc_emulator_sync_edge_det.sv | 41 ++++
 rtl/ad4003_adc_emulator.sv | 152 +++++++++++++++
 tb/tb_ad4003_adc_emulator.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/ad4003_pkg.sv
// rtl/ad4003_pkg.sv - shared constants and helpers for the AD4003 lane emulator
//
// Purpose : frame geometry, command opcodes, the turbo config value and the
//           register read-back frame builder shared by the emulator files.
// Ports   : none (package).
package ad4003_pkg;

  localparam int ADC_DATA_WIDTH = 18;
  localparam int CMD_BITS       = 16;

  localparam logic [7:0] AD4003_CMD_WR    = 8'h14;
  localparam logic [7:0] AD4003_CMD_RD    = 8'h54;
  localparam logic [7:0] AD4003_CFG_TURBO = 8'h03;

  // Frame returned after a register read command: the config byte sits in
  // the middle of an otherwise zero sample word.
  function automatic logic [ADC_DATA_WIDTH-1:0] rd_resp(input logic [7:0] cfg);
    return {8'h00, cfg, 2'b00};
  endfunction

endpackage

// File: rtl/ad4003_adc_emulator_sync_edge_det.sv
// rtl/ad4003_adc_emulator_sync_edge_det.sv - 2-flop synchronizer with registered edge strobes
//
// Purpose : brings one asynchronous host pin into the clk domain and produces
//           one-cycle rise/fall strobes. The strobes and the level output are
//           aligned: all three reflect the same pin sample, 3 cycles late.
// Ports   : clk    in  sampling clock
//           rst_n  in  asynchronous active-low reset
//           d      in  asynchronous pin
//           q      out synchronized level, aligned with the strobes
//           rise   out one-cycle strobe on a 0->1 pin transition
//           fall   out one-cycle strobe on a 1->0 pin transition
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= d;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
      fall <= ~s2 & s3;
    end
  end

  assign q = s3;

endmodule

// File: rtl/ad4003_adc_emulator.sv
// rtl/ad4003_adc_emulator.sv - AD4003 3-wire turbo-mode ADC responder for one lane
//
// Purpose : oversamples host CNV/SCK/SDI, runs the conversion timer, shifts the
//           previously converted sample out on SDO and decodes 16-bit register
//           write/read commands arriving on SDI.
// Ports   : clk_100    in  system clock (>= 4x SCK)
//           rst_n      in  asynchronous active-low reset
//           cnv_i      in  host conversion start (async)
//           sck_i      in  host serial clock (async)
//           sdi_i      in  host serial data in (async)
//           sample_i   in  value captured at the end of each conversion
//           sdo_o      out serial data to host, MSB first
//           cfg_o      out emulated configuration register
//           busy_o     out conversion in progress
//           cfg_wr_o   out one-cycle pulse when cfg_o is written
//           err_o      out sticky protocol-error flag
//           err_clr_i  in  synchronous clear of err_o
import ad4003_pkg::*;

module ad4003_adc_emulator #(
  parameter int ADC_DATA_WIDTH = 18,
  parameter int CONV_CYCLES    = 29
) (
  input  logic                      clk_100,
  input  logic                      rst_n,
  input  logic                      cnv_i,
  input  logic                      sck_i,
  input  logic                      sdi_i,
  input  logic [ADC_DATA_WIDTH-1:0] sample_i,
  output logic                      sdo_o,
  output logic [7:0]                cfg_o,
  output logic                      busy_o,
  output logic                      cfg_wr_o,
  output logic                      err_o,
  input  logic                      err_clr_i
);

  localparam int BCW = $clog2(ADC_DATA_WIDTH + 1);
  localparam int CCW = $clog2(CONV_CYCLES + 1);

  // bit_cnt == FRAME_END means "no frame open": reset value and post-frame.
  localparam logic [BCW-1:0] FRAME_END = BCW'(ADC_DATA_WIDTH);
  localparam logic [BCW-1:0] CMD_END   = BCW'(CMD_BITS);
  localparam logic [BCW-1:0] CMD_LAST  = BCW'(CMD_BITS - 1);
  localparam logic [CCW-1:0] CONV_LOAD = CCW'(CONV_CYCLES);
  localparam logic [CCW-1:0] CONV_ONE  = CCW'(1);

  logic cnv_rise, cnv_fall, cnv_lvl;
  logic sck_rise, sck_fall, sck_lvl;
  logic sdi_rise, sdi_fall, sdi_s;

  sync_edge_det u_sync_cnv (.clk(clk_100), .rst_n(rst_n), .d(cnv_i), .q(cnv_lvl), .rise(cnv_rise), .fall(cnv_fall));
  sync_edge_det u_sync_sck (.clk(clk_100), .rst_n(rst_n), .d(sck_i), .q(sck_lvl), .rise(sck_rise), .fall(sck_fall));
  sync_edge_det u_sync_sdi (.clk(clk_100), .rst_n(rst_n), .d(sdi_i), .q(sdi_s),   .rise(sdi_rise), .fall(sdi_fall));

  logic unused_sync;
  assign unused_sync = ^{cnv_fall, cnv_lvl, sck_lvl, sdi_rise, sdi_fall};

  logic [ADC_DATA_WIDTH-1:0] held_sample;
  logic [ADC_DATA_WIDTH-1:0] sr;
  logic [CMD_BITS-1:0]       cmd_sr;
  logic [CMD_BITS-1:0]       cmd_next;
  logic [BCW-1:0]            bit_cnt;
  logic [CCW-1:0]            conv_cnt;
  logic                      rd_pending;
  logic                      err_set;

  assign cmd_next = {cmd_sr[CMD_BITS-2:0], sdi_s};

  // SDO is the shift register MSB; the register itself is the output flop.
  assign sdo_o = sr[ADC_DATA_WIDTH-1];

  // Conversion timer. A CNV rise while busy simply restarts the count, so
  // held_sample only updates when a conversion runs to completion.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      busy_o      <= 1'b0;
      conv_cnt    <= '0;
      held_sample <= '0;
    end else if (cnv_rise) begin
      busy_o   <= 1'b1;
      conv_cnt <= CONV_LOAD;
    end else if (busy_o) begin
      if (conv_cnt == CONV_ONE) begin
        busy_o      <= 1'b0;
        conv_cnt    <= '0;
        held_sample <= sample_i;
      end else begin
        conv_cnt <= conv_cnt - CONV_ONE;
      end
    end
  end

  // Frame engine. CNV rise dominates any SCK strobe in the same cycle.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      sr         <= '0;
      cmd_sr     <= '0;
      bit_cnt    <= FRAME_END;
      rd_pending <= 1'b0;
      cfg_o      <= 8'h00;
      cfg_wr_o   <= 1'b0;
    end else begin
      cfg_wr_o <= 1'b0;
      if (cnv_rise) begin
        // Turbo: the frame carries the previous conversion or the read-back.
        sr         <= rd_pending ? rd_resp(cfg_o) : held_sample;
        bit_cnt    <= '0;
        rd_pending <= 1'b0;
        cmd_sr     <= '0;
      end else if (sck_rise) begin
        if (bit_cnt < FRAME_END) begin
          if (bit_cnt < CMD_END) begin
            cmd_sr <= cmd_next;
          end
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CMD_LAST) begin
            if (cmd_next[15:8] == AD4003_CMD_WR) begin
              cfg_o    <= cmd_next[7:0];
              cfg_wr_o <= 1'b1;
            end else if (cmd_next[15:8] == AD4003_CMD_RD) begin
              rd_pending <= 1'b1;
            end
          end
        end
      end else if (sck_fall) begin
        sr <= {sr[ADC_DATA_WIDTH-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    err_set = 1'b0;
    if (cnv_rise) begin
      err_set = busy_o || ((bit_cnt != '0) && (bit_cnt < FRAME_END));
    end else if (sck_rise) begin
      err_set = (bit_cnt >= FRAME_END);
    end
  end

  // Sticky error; a new error in the same cycle as the clear wins.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      err_o <= 1'b0;
    end else if (err_set) begin
      err_o <= 1'b1;
    end else if (err_clr_i) begin
      err_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ad4003_adc_emulator.sv
// tb/tb_ad4003_adc_emulator.sv - directed self-checking bench for ad4003_adc_emulator
module tb_ad4003_adc_emulator;

  localparam int HALF = 6;

  logic        clk_100 = 1'b0;
  logic        rst_n;
  logic        cnv, sck, sdi, err_clr;
  logic [17:0] sample;
  logic        sdo, busy, cfg_wr, err;
  logic [7:0]  cfg;

  int n_cmp = 0;
  int n_bad = 0;
  int busy_cycles = 0;
  int wr_pulses = 0;
  int b0, w0;
  logic [19:0] got;

  ad4003_adc_emulator #(.ADC_DATA_WIDTH(18), .CONV_CYCLES(29)) dut (
    .clk_100  (clk_100),
    .rst_n    (rst_n),
    .cnv_i    (cnv),
    .sck_i    (sck),
    .sdi_i    (sdi),
    .sample_i (sample),
    .sdo_o    (sdo),
    .cfg_o    (cfg),
    .busy_o   (busy),
    .cfg_wr_o (cfg_wr),
    .err_o    (err),
    .err_clr_i(err_clr)
  );

  always #5 clk_100 = ~clk_100;

  always @(negedge clk_100) begin
    if (busy)   busy_cycles++;
    if (cfg_wr) wr_pulses++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_100);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One host frame: CNV pulse, then nsck SCK cycles; SDO is sampled just
  // before each SCK rise. rst_at >= 0 asserts reset in that bit's low phase.
  task automatic frame(input logic [17:0] bits, input int nsck, input int rst_at,
                       output logic [19:0] rx);
    rx  = '0;
    cnv = 1'b1;
    tick(2);
    cnv = 1'b0;
    for (int i = 0; i < nsck; i++) begin
      sdi = (i < 18) ? bits[17-i] : 1'b0;
      tick(HALF);
      if (i == rst_at) begin
        rst_n = 1'b0;
        tick(2);
        return;
      end
      rx  = {rx[18:0], sdo};
      sck = 1'b1;
      tick(HALF);
      sck = 1'b0;
    end
    tick(HALF + 4);
    sdi = 1'b0;
  endtask

  task automatic clear_err(input string tag);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
    chk(tag, {31'd0, err}, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_sdo"},    {31'd0, sdo},    32'd0);
    chk({pfx, "_cfg"},    {24'd0, cfg},    32'd0);
    chk({pfx, "_busy"},   {31'd0, busy},   32'd0);
    chk({pfx, "_cfg_wr"}, {31'd0, cfg_wr}, 32'd0);
    chk({pfx, "_err"},    {31'd0, err},    32'd0);
  endtask

  initial begin
    rst_n = 1'b0; cnv = 1'b0; sck = 1'b0; sdi = 1'b0; err_clr = 1'b0;
    sample = 18'h2A5A5;
    tick(3);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    tick(2);

    // Conversion with no clocks; busy lasts exactly 29 cycles.
    b0 = busy_cycles;
    frame(18'h3FFFF, 0, -1, got);
    tick(40);
    chk("busy_len", busy_cycles - b0, 32'd29);

    // Turbo read-out of the previous conversion.
    frame(18'h3FFFF, 18, -1, got);
    chk("sample_rd", {14'd0, got[17:0]}, 32'h2A5A5);
    chk("sample_err", {31'd0, err}, 32'd0);

    // Register write 0x14 0x03.
    w0 = wr_pulses;
    frame({16'h1403, 2'b11}, 18, -1, got);
    chk("wr_sample", {14'd0, got[17:0]}, 32'h2A5A5);
    chk("wr_pulses", wr_pulses - w0, 32'd1);
    chk("wr_cfg", {24'd0, cfg}, 32'h03);

    // Register read 0x54, answered in the next frame.
    frame({16'h54FF, 2'b11}, 18, -1, got);
    chk("rd_cmd_sample", {14'd0, got[17:0]}, 32'h2A5A5);
    frame(18'h3FFFF, 18, -1, got);
    chk("rd_resp", {14'd0, got[17:0]}, 32'h0000C);
    chk("rd_cfg_bits", {27'd0, got[6:2]}, 32'h03);
    chk("rd_err", {31'd0, err}, 32'd0);

    // Frame aborted after 9 bits of a 0x1455 write.
    w0 = wr_pulses;
    frame({16'h1455, 2'b11}, 9, -1, got);
    frame(18'h3FFFF, 18, -1, got);
    chk("abort_err", {31'd0, err}, 32'd1);
    chk("abort_cfg", {24'd0, cfg}, 32'h03);
    chk("abort_nowr", wr_pulses - w0, 32'd0);
    chk("abort_msb", {14'd0, got[17:0]}, 32'h2A5A5);
    clear_err("abort_clr");

    // CNV while a conversion is still running.
    cnv = 1'b1; tick(2); cnv = 1'b0; tick(8);
    cnv = 1'b1; tick(2); cnv = 1'b0; tick(6);
    chk("busy_cnv_err", {31'd0, err}, 32'd1);
    chk("busy_cnv_busy", {31'd0, busy}, 32'd1);
    tick(40);
    clear_err("busy_cnv_clr");

    // 20 clocks: the extra two bits read zero and flag an error.
    frame(18'h3FFFF, 20, -1, got);
    chk("over_bits", {12'd0, got}, 32'hA9694);
    chk("over_err", {31'd0, err}, 32'd1);
    clear_err("over_clr");

    // Reset mid-frame during a write, then clean operation.
    frame({16'h14AA, 2'b11}, 18, 7, got);
    chk_reset_outputs("midrst");
    rst_n = 1'b1;
    tick(4);
    w0 = wr_pulses;
    frame({16'h1455, 2'b11}, 18, -1, got);
    chk("post_rst_sample", {14'd0, got[17:0]}, 32'h00000);
    chk("post_rst_cfg", {24'd0, cfg}, 32'h55);
    chk("post_rst_wr", wr_pulses - w0, 32'd1);
    frame(18'h3FFFF, 18, -1, got);
    chk("post_rst_sample2", {14'd0, got[17:0]}, 32'h2A5A5);
    chk("post_rst_err", {31'd0, err}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
